// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC pipeline writeback slice: select encodings,
// FSM states, the MEM/WB field bundle and the helpers that decode it.
package wisc_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        WBSEL_ALU = 2'd0,
        WBSEL_MEM = 2'd1,
        WBSEL_PC2 = 2'd2,
        WBSEL_IMM = 2'd3
    } wbsel_e;

    typedef enum logic [1:0] {
        REGDST_RD_I1 = 2'd0,
        REGDST_RD_R  = 2'd1,
        REGDST_RS_I2 = 2'd2,
        REGDST_R7    = 2'd3
    } regdst_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_HALTED   = 2'd3
    } wb_state_e;

    typedef struct packed {
        logic              regwrite;
        logic              halt;
        wbsel_e            wbsel;
        logic [2:0]        sel;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] pc2;
        logic [DATA_W-1:0] imm;
    } wb_fields_t;

    // dst_bits is Instr[10:2]: [8:6]=Instr[10:8], [5:3]=Instr[7:5], [2:0]=Instr[4:2]
    function automatic logic [2:0] decode_sel(input regdst_e regdst, input logic [8:0] dst_bits);
        logic [2:0] sel;
        case (regdst)
            REGDST_RD_I1: sel = dst_bits[5:3];
            REGDST_RD_R:  sel = dst_bits[2:0];
            REGDST_RS_I2: sel = dst_bits[8:6];
            REGDST_R7:    sel = 3'd7;
            default:      sel = 3'd0;
        endcase
        return sel;
    endfunction

    function automatic logic [DATA_W-1:0] wb_mux(input wb_fields_t f, input logic [DATA_W-1:0] mem_data);
        logic [DATA_W-1:0] data;
        case (f.wbsel)
            WBSEL_ALU: data = f.alu;
            WBSEL_MEM: data = mem_data;
            WBSEL_PC2: data = f.pc2;
            WBSEL_IMM: data = f.imm;
            default:   data = f.alu;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register bank: loads the captured instruction fields and
// clears on reset or when a load is abandoned.
module wb_pipe_reg
    import wisc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       ld,
    input  wb_fields_t d,
    output wb_fields_t q
);

    wb_fields_t q_r;

    // Field storage with synchronous clear taking priority over load
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q_r <= '0;
        end else if (ld) begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: holds the MEM/WB instruction, waits for load data and
// drives the register-file write port (which decode also uses as its bypass).
module writeback_stage
    import wisc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        m_valid,
    input  logic [15:0] m_instr,
    input  logic [1:0]  m_regdst,
    input  logic        m_regwrite,
    input  logic [1:0]  m_wbsel,
    input  logic [15:0] m_alu,
    input  logic [15:0] m_pc2,
    input  logic [15:0] m_imm,
    input  logic        m_memread,
    input  logic        m_halt,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic        wb_ready,
    output logic        wr_en,
    output logic [2:0]  wr_sel,
    output logic [15:0] wr_data,
    output logic        halted,
    output logic        err
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

    wb_state_e          state_r;
    wb_state_e          state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx_s;
    logic [DATA_W-1:0]  mem_data_r;
    logic [DATA_W-1:0]  mem_data_nx_s;
    logic               err_r;
    logic               err_nx_s;
    logic               halted_r;
    logic               halted_nx_s;
    logic               wb_ready_r;
    logic               wb_ready_nx_s;
    logic               wr_en_r;
    logic               wr_en_nx_s;
    logic [2:0]         wr_sel_r;
    logic [DATA_W-1:0]  wr_data_r;
    logic [DATA_W-1:0]  wr_data_nx_s;

    logic               capture_s;
    logic               clr_s;
    wb_fields_t         pipe_d_s;
    wb_fields_t         pipe_q_s;
    wb_fields_t         fields_nx_s;
    logic               unused_s;

    assign unused_s = ^{m_instr[15:11], m_instr[1:0]};

    // Pack the incoming instruction; the destination register is decoded here
    always_comb begin
        pipe_d_s          = '0;
        pipe_d_s.regwrite = m_regwrite;
        pipe_d_s.halt     = m_halt;
        pipe_d_s.wbsel    = wbsel_e'(m_wbsel);
        pipe_d_s.sel      = decode_sel(regdst_e'(m_regdst), m_instr[10:2]);
        pipe_d_s.alu      = m_alu;
        pipe_d_s.pc2      = m_pc2;
        pipe_d_s.imm      = m_imm;
    end

    wb_pipe_reg u_pipe (
        .clk (clk),
        .rst (rst),
        .clr (clr_s),
        .ld  (capture_s),
        .d   (pipe_d_s),
        .q   (pipe_q_s)
    );

    // Next-state, timeout counter and sticky flag logic
    always_comb begin
        capture_s     = m_valid && wb_ready_r;
        state_nx_s    = state_r;
        cnt_nx_s      = cnt_r;
        mem_data_nx_s = mem_data_r;
        halted_nx_s   = halted_r;
        clr_s         = 1'b0;

        // load data nobody asked for is flagged and dropped
        if (mem_done && (state_r != ST_WAIT_MEM)) begin
            err_nx_s = 1'b1;
        end else begin
            err_nx_s = err_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (capture_s) begin
                    state_nx_s = m_memread ? ST_WAIT_MEM : ST_COMMIT;
                    cnt_nx_s   = 8'd0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_done) begin
                    mem_data_nx_s = mem_rdata;
                    state_nx_s    = ST_COMMIT;
                    cnt_nx_s      = 8'd0;
                end else if (cnt_r == TO_LAST) begin
                    err_nx_s   = 1'b1;
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = 8'd0;
                    clr_s      = 1'b1;
                end else begin
                    cnt_nx_s = cnt_r + 8'd1;
                end
            end
            ST_COMMIT: begin
                if (pipe_q_s.halt) begin
                    halted_nx_s = 1'b1;
                    state_nx_s  = ST_HALTED;
                end else if (capture_s) begin
                    state_nx_s = m_memread ? ST_WAIT_MEM : ST_COMMIT;
                    cnt_nx_s   = 8'd0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_HALTED: begin
                state_nx_s = ST_HALTED;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Port values for the coming cycle, derived from the instruction about to commit
    always_comb begin
        if (capture_s) begin
            fields_nx_s = pipe_d_s;
        end else begin
            fields_nx_s = pipe_q_s;
        end
        wr_en_nx_s    = (state_nx_s == ST_COMMIT) && fields_nx_s.regwrite && !fields_nx_s.halt;
        wr_data_nx_s  = wb_mux(fields_nx_s, mem_data_nx_s);
        wb_ready_nx_s = (state_nx_s == ST_IDLE) ||
                        ((state_nx_s == ST_COMMIT) && !fields_nx_s.halt);
    end

    // State and registered outputs; write port holds its last value between strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            mem_data_r <= 16'd0;
            err_r      <= 1'b0;
            halted_r   <= 1'b0;
            wb_ready_r <= 1'b1;
            wr_en_r    <= 1'b0;
            wr_sel_r   <= 3'd0;
            wr_data_r  <= 16'd0;
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            mem_data_r <= mem_data_nx_s;
            err_r      <= err_nx_s;
            halted_r   <= halted_nx_s;
            wb_ready_r <= wb_ready_nx_s;
            wr_en_r    <= wr_en_nx_s;
            if (wr_en_nx_s) begin
                wr_sel_r  <= fields_nx_s.sel;
                wr_data_r <= wr_data_nx_s;
            end
        end
    end

    assign wb_ready = wb_ready_r;
    assign wr_en    = wr_en_r;
    assign wr_sel   = wr_sel_r;
    assign wr_data  = wr_data_r;
    assign halted   = halted_r;
    assign err      = err_r;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: hand-computed vectors for ALU, load,
// JAL/back-to-back, timeout, stray mem_done, HALT and reset-during-load.
module tb_writeback_stage;

    logic        clk;
    logic        rst;
    logic        m_valid;
    logic [15:0] m_instr;
    logic [1:0]  m_regdst;
    logic        m_regwrite;
    logic [1:0]  m_wbsel;
    logic [15:0] m_alu;
    logic [15:0] m_pc2;
    logic [15:0] m_imm;
    logic        m_memread;
    logic        m_halt;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        wb_ready;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [15:0] wr_data;
    logic        halted;
    logic        err;

    int total = 0;
    int bad   = 0;

    writeback_stage #(.MEM_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .m_valid    (m_valid),
        .m_instr    (m_instr),
        .m_regdst   (m_regdst),
        .m_regwrite (m_regwrite),
        .m_wbsel    (m_wbsel),
        .m_alu      (m_alu),
        .m_pc2      (m_pc2),
        .m_imm      (m_imm),
        .m_memread  (m_memread),
        .m_halt     (m_halt),
        .mem_done   (mem_done),
        .mem_rdata  (mem_rdata),
        .wb_ready   (wb_ready),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .halted     (halted),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        m_valid    = 1'b0;
        m_instr    = 16'h0000;
        m_regdst   = 2'b00;
        m_regwrite = 1'b0;
        m_wbsel    = 2'b00;
        m_alu      = 16'h0000;
        m_pc2      = 16'h0000;
        m_imm      = 16'h0000;
        m_memread  = 1'b0;
        m_halt     = 1'b0;
    endtask

    task automatic put_op(input logic [1:0] regdst, input logic [15:0] instr, input logic [1:0] wbsel,
                          input logic [15:0] alu, input logic [15:0] pc2, input logic [15:0] imm,
                          input logic memread, input logic halt, input logic regwrite);
        m_valid    = 1'b1;
        m_regdst   = regdst;
        m_instr    = instr;
        m_wbsel    = wbsel;
        m_alu      = alu;
        m_pc2      = pc2;
        m_imm      = imm;
        m_memread  = memread;
        m_halt     = halt;
        m_regwrite = regwrite;
    endtask

    task automatic check_reset_outs(input string tag);
        @(negedge clk);
        check_eq({tag, "_wr_en"},    32'(wr_en),    32'd0);
        check_eq({tag, "_wr_sel"},   32'(wr_sel),   32'd0);
        check_eq({tag, "_wr_data"},  32'(wr_data),  32'd0);
        check_eq({tag, "_halted"},   32'(halted),   32'd0);
        check_eq({tag, "_err"},      32'(err),      32'd0);
        check_eq({tag, "_wb_ready"}, 32'(wb_ready), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int wr_seen;
        logic [15:0] exp_d;
        clear_in();
        mem_done  = 1'b0;
        mem_rdata = 16'h0000;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outs("reset");

        // ALU op, regdst=01 -> Instr[4:2]=3 (other fields differ: [7:5]=6, [10:8]=1)
        tick();
        put_op(2'b01, 16'h01CC, 2'b00, 16'h1234, 16'hBB01, 16'hCC01, 1'b0, 1'b0, 1'b1);
        tick();
        clear_in();
        @(negedge clk);
        check_eq("alu_wr_en",   32'(wr_en),   32'd1);
        check_eq("alu_wr_sel",  32'(wr_sel),  32'd3);
        check_eq("alu_wr_data", 32'(wr_data), 32'h1234);
        tick();
        @(negedge clk);
        check_eq("alu_pulse_end", 32'(wr_en),   32'd0);
        check_eq("alu_hold_data", 32'(wr_data), 32'h1234);
        check_eq("alu_hold_sel",  32'(wr_sel),  32'd3);

        // Load, regdst=00 -> Instr[7:5]=5; mem_done in third wait cycle
        tick();
        put_op(2'b00, 16'h02A4, 2'b01, 16'hAAAA, 16'hBBBB, 16'hCCCC, 1'b1, 1'b0, 1'b1);
        tick();
        clear_in();
        @(negedge clk);
        check_eq("ld_wait_ready", 32'(wb_ready), 32'd0);
        check_eq("ld_wait_wr_en", 32'(wr_en),    32'd0);
        tick();
        tick();
        mem_done  = 1'b1;
        mem_rdata = 16'hBEEF;
        @(negedge clk);
        check_eq("ld_wait3_ready", 32'(wb_ready), 32'd0);
        tick();
        mem_done  = 1'b0;
        mem_rdata = 16'h0000;
        @(negedge clk);
        check_eq("ld_wr_en",   32'(wr_en),   32'd1);
        check_eq("ld_wr_sel",  32'(wr_sel),  32'd5);
        check_eq("ld_wr_data", 32'(wr_data), 32'hBEEF);
        check_eq("ld_err",     32'(err),     32'd0);

        // JAL to R7, then four back-to-back ops to Instr[10:8]=i
        tick();
        put_op(2'b11, 16'h0000, 2'b10, 16'hA0A0, 16'h0042, 16'hC0C0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 1; i <= 4; i++) begin
            put_op(2'b10, 16'h00FC | 16'(i << 8), (i == 4) ? 2'b11 : 2'b00,
                   16'hA000 | 16'(i), 16'hB000 | 16'(i), 16'hC000 | 16'(i), 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            if (i == 1) begin
                check_eq("jal_wr_en",   32'(wr_en),   32'd1);
                check_eq("jal_wr_sel",  32'(wr_sel),  32'd7);
                check_eq("jal_wr_data", 32'(wr_data), 32'h0042);
            end else begin
                check_eq("b2b_wr_en",   32'(wr_en),   32'd1);
                check_eq("b2b_wr_sel",  32'(wr_sel),  32'(i - 1));
                check_eq("b2b_wr_data", 32'(wr_data), 32'(16'hA000 | 16'(i - 1)));
            end
            check_eq("b2b_ready", 32'(wb_ready), 32'd1);
            tick();
        end
        clear_in();
        @(negedge clk);
        check_eq("b2b4_wr_en",   32'(wr_en),   32'd1);
        check_eq("b2b4_wr_sel",  32'(wr_sel),  32'd4);
        check_eq("b2b4_wr_data", 32'(wr_data), 32'hC004);
        tick();
        @(negedge clk);
        check_eq("b2b_done_wr_en", 32'(wr_en), 32'd0);

        // Timeout: load with no mem_done; 16 wait cycles then err
        tick();
        put_op(2'b01, 16'h0008, 2'b01, 16'h1111, 16'h2222, 16'h3333, 1'b1, 1'b0, 1'b1);
        tick();
        clear_in();
        wr_seen = 0;
        for (int c = 1; c < 16; c++) begin
            @(negedge clk);
            if (wr_en) wr_seen++;
            tick();
        end
        @(negedge clk);
        check_eq("to_wait16_err",   32'(err),      32'd0);
        check_eq("to_wait16_ready", 32'(wb_ready), 32'd0);
        check_eq("to_no_write",     32'(wr_seen),  32'd0);
        tick();
        @(negedge clk);
        check_eq("to_err",      32'(err),      32'd1);
        check_eq("to_idle_rdy", 32'(wb_ready), 32'd1);
        check_eq("to_wr_en",    32'(wr_en),    32'd0);
        check_eq("to_hold",     32'(wr_data),  32'hC004);
        tick();

        // Stray mem_done in IDLE
        do_reset();
        @(negedge clk);
        check_eq("stray_pre_err", 32'(err), 32'd0);
        tick();
        mem_done  = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        mem_done  = 1'b0;
        @(negedge clk);
        check_eq("stray_err",   32'(err),      32'd1);
        check_eq("stray_ready", 32'(wb_ready), 32'd1);
        check_eq("stray_wr_en", 32'(wr_en),    32'd0);
        tick();

        // HALT after an ALU op
        do_reset();
        put_op(2'b01, 16'h0010, 2'b00, 16'hCAFE, 16'h0101, 16'h0202, 1'b0, 1'b0, 1'b1);
        tick();
        put_op(2'b01, 16'h0014, 2'b00, 16'h9999, 16'h0101, 16'h0202, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check_eq("hlt_alu_wr_en",   32'(wr_en),   32'd1);
        check_eq("hlt_alu_wr_sel",  32'(wr_sel),  32'd4);
        check_eq("hlt_alu_wr_data", 32'(wr_data), 32'hCAFE);
        tick();
        clear_in();
        @(negedge clk);
        check_eq("hlt_commit_wr_en", 32'(wr_en),    32'd0);
        check_eq("hlt_commit_ready", 32'(wb_ready), 32'd0);
        tick();
        put_op(2'b01, 16'h001C, 2'b00, 16'h7777, 16'h0101, 16'h0202, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_eq("hlt_halted", 32'(halted),   32'd1);
        check_eq("hlt_ready",  32'(wb_ready), 32'd0);
        tick();
        tick();
        tick();
        @(negedge clk);
        check_eq("hlt_stay_halted", 32'(halted),   32'd1);
        check_eq("hlt_stay_ready",  32'(wb_ready), 32'd0);
        check_eq("hlt_stay_wr_en",  32'(wr_en),    32'd0);
        check_eq("hlt_stay_data",   32'(wr_data),  32'hCAFE);
        clear_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outs("hlt_rst");

        // Reset in second wait cycle together with mem_done
        tick();
        put_op(2'b00, 16'h02A4, 2'b01, 16'h1212, 16'h3434, 16'h5656, 1'b1, 1'b0, 1'b1);
        tick();
        clear_in();
        tick();
        rst       = 1'b1;
        mem_done  = 1'b1;
        mem_rdata = 16'h4321;
        tick();
        rst       = 1'b0;
        mem_done  = 1'b0;
        @(negedge clk);
        check_eq("rstld_wr_en", 32'(wr_en),    32'd0);
        check_eq("rstld_err",   32'(err),      32'd0);
        check_eq("rstld_ready", 32'(wb_ready), 32'd1);
        check_eq("rstld_data",  32'(wr_data),  32'd0);
        tick();
        @(negedge clk);
        check_eq("rstld_late_wr_en", 32'(wr_en), 32'd0);
        check_eq("rstld_late_err",   32'(err),   32'd0);
        // IDLE accepts and commits next cycle; IMM select
        tick();
        exp_d = 16'h0F0F;
        put_op(2'b10, 16'h0600, 2'b11, 16'h1010, 16'h2020, exp_d, 1'b0, 1'b0, 1'b1);
        tick();
        clear_in();
        @(negedge clk);
        check_eq("post_wr_en",   32'(wr_en),   32'd1);
        check_eq("post_wr_sel",  32'(wr_sel),  32'd6);
        check_eq("post_wr_data", 32'(wr_data), 32'(exp_d));

        // regwrite=0 commits without a strobe
        tick();
        put_op(2'b01, 16'h0004, 2'b00, 16'h5555, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        clear_in();
        @(negedge clk);
        check_eq("nowr_wr_en", 32'(wr_en),   32'd0);
        check_eq("nowr_hold",  32'(wr_data), 32'(exp_d));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
